// File: rtl/cbi980_pkg.sv
// Shared types and constants for the cbi980 register-port arbiter.
package cbi980_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/cbi980_rr_arb.sv
// Rotating-priority picker: grants the first asserted request at or after ptr.
module cbi980_rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cbi980_regarb.sv
// Round-robin arbiter sharing the cbi980_core register port among NREQ requesters,
// sequencing write/read strobes and returning the response on a valid/ready channel.
//
// state | meaning
// IDLE  | offering req_ready to the rotating-priority winner
// WRITE | one-cycle core_wr_en, capture core_wr_err
// READ  | core_rd_valid_in held until completion or timeout
// RESP  | rsp_valid to the granted requester until its rsp_ready
module cbi980_regarb
    import cbi980_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                   aclk,
    input  logic                   arstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [ADDR_W-1:0]      core_wr_addr,
    output logic [DATA_W-1:0]      core_wr_data,
    output logic                   core_wr_en,
    input  logic                   core_wr_err,
    output logic [ADDR_W-1:0]      core_rd_addr,
    output logic                   core_rd_valid_in,
    input  logic [DATA_W-1:0]      core_rd_data,
    input  logic                   core_rd_valid_out
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(RD_TIMEOUT);

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  to_cnt;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_code;
    logic [NREQ-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;

    // Assert asynchronously, release two clocks later so all flops leave reset together.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    cbi980_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Down-counter loaded at accept; reaching zero marks the last allowed read cycle.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            to_cnt     <= '0;
            rsp_data_q <= '0;
            rsp_code   <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (|arb_grant) begin
                        gnt_idx   <= arb_idx;
                        lat_addr  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                        lat_wdata <= req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
                        to_cnt    <= CNT_W'(RD_TIMEOUT - 1);
                        state     <= req_write[arb_idx] ? WRITE : READ;
                    end
                end
                WRITE: begin
                    rsp_data_q <= '0;
                    rsp_code   <= core_wr_err ? RESP_SLVERR : RESP_OKAY;
                    state      <= RESP;
                end
                READ: begin
                    if (core_rd_valid_out) begin
                        rsp_data_q <= core_rd_data;
                        rsp_code   <= RESP_OKAY;
                        state      <= RESP;
                    end else if (to_cnt == '0) begin
                        rsp_data_q <= '0;
                        rsp_code   <= RESP_SLVERR;
                        state      <= RESP;
                    end else begin
                        to_cnt <= to_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        ptr        <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                        rsp_data_q <= '0;
                        rsp_code   <= RESP_OKAY;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready        = (state == IDLE && rst_n) ? arb_grant : '0;
    assign rsp_valid        = (state == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign rsp_data         = rsp_data_q;
    assign rsp_err          = (rsp_code == RESP_SLVERR);
    assign core_wr_en       = (state == WRITE);
    assign core_rd_valid_in = (state == READ);
    assign core_wr_addr     = lat_addr;
    assign core_rd_addr     = lat_addr;
    assign core_wr_data     = lat_wdata;

endmodule

// File: tb/tb_cbi980_regarb.sv
// Directed self-checking bench for cbi980_regarb (NREQ=2, RD_TIMEOUT=16).
module tb_cbi980_regarb;

    logic        aclk = 1'b0;
    logic        arstn;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid, rsp_ready;
    logic [5:0]  req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_data, core_wr_data, core_rd_data;
    logic        rsp_err, core_wr_en, core_wr_err, core_rd_valid_in, core_rd_valid_out;
    logic [2:0]  core_wr_addr, core_rd_addr;

    int vec_cnt = 0;
    int err_cnt = 0;

    cbi980_regarb #(.NREQ(2), .ADDR_W(3), .DATA_W(32), .RD_TIMEOUT(16)) dut (
        .aclk(aclk), .arstn(arstn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_wr_en(core_wr_en), .core_wr_err(core_wr_err), .core_rd_addr(core_rd_addr),
        .core_rd_valid_in(core_rd_valid_in), .core_rd_data(core_rd_data),
        .core_rd_valid_out(core_rd_valid_out)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_inputs();
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
        core_wr_err = 1'b0; core_rd_data = '0; core_rd_valid_out = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [2:0] a, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i*3 +: 3] = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic next_cycle();
        @(posedge aclk); #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        arstn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 arstn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        arstn = 1'b0;
        req_valid = 2'b11;
        #7;
        vec_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
        vec_cnt++; if ({rsp_valid, rsp_err, core_wr_en, core_rd_valid_in} !== 5'b0) begin err_cnt++; $display("FAIL reset_ctrl: got %b exp 00000", {rsp_valid, rsp_err, core_wr_en, core_rd_valid_in}); end
        vec_cnt++; if ({rsp_data, core_wr_data, core_wr_addr, core_rd_addr} !== 70'b0) begin err_cnt++; $display("FAIL reset_data: got %h exp 0", {rsp_data, core_wr_data, core_wr_addr, core_rd_addr}); end
        do_reset();
        @(negedge aclk);
        vec_cnt++; if ({req_ready, rsp_valid, core_wr_en, core_rd_valid_in} !== 6'b0) begin err_cnt++; $display("FAIL post_reset_idle: got %b exp 0", {req_ready, rsp_valid, core_wr_en, core_rd_valid_in}); end
        next_cycle();
    endtask

    task automatic test_write();
        do_reset();
        set_req(0, 1'b1, 3'd3, 32'hDEADBEEF);
        @(negedge aclk);
        vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL wr_accept: got %b exp 01", req_ready); end
        vec_cnt++; if (core_wr_en !== 1'b0) begin err_cnt++; $display("FAIL wr_en_c0: got %b exp 0", core_wr_en); end
        next_cycle();
        req_valid = '0;
        @(negedge aclk);
        vec_cnt++; if (core_wr_en !== 1'b1) begin err_cnt++; $display("FAIL wr_en_c1: got %b exp 1", core_wr_en); end
        vec_cnt++; if (core_wr_addr !== 3'd3) begin err_cnt++; $display("FAIL wr_addr: got %0d exp 3", core_wr_addr); end
        vec_cnt++; if (core_wr_data !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL wr_data: got %h exp deadbeef", core_wr_data); end
        vec_cnt++; if ({rsp_valid, core_rd_valid_in} !== 3'b000) begin err_cnt++; $display("FAIL wr_c1_other: got %b exp 000", {rsp_valid, core_rd_valid_in}); end
        next_cycle();
        @(negedge aclk);
        vec_cnt++; if (core_wr_en !== 1'b0) begin err_cnt++; $display("FAIL wr_en_c2: got %b exp 0", core_wr_en); end
        vec_cnt++; if (rsp_valid !== 2'b01) begin err_cnt++; $display("FAIL wr_rsp_valid: got %b exp 01", rsp_valid); end
        vec_cnt++; if ({rsp_err, rsp_data} !== 33'b0) begin err_cnt++; $display("FAIL wr_rsp: got err=%b data=%h exp 0/0", rsp_err, rsp_data); end
        rsp_ready = 2'b01;
        next_cycle();
        rsp_ready = '0;
        @(negedge aclk);
        vec_cnt++; if ({rsp_valid, core_wr_en} !== 3'b000) begin err_cnt++; $display("FAIL wr_done: got %b exp 000", {rsp_valid, core_wr_en}); end
        next_cycle();
    endtask

    task automatic test_fairness();
        logic [1:0]  eg;
        logic [2:0]  ea;
        do_reset();
        set_req(0, 1'b0, 3'd1, 32'h0);
        set_req(1, 1'b0, 3'd2, 32'h0);
        rsp_ready = 2'b11;
        core_rd_valid_out = 1'b1;
        for (int t = 0; t < 4; t++) begin
            eg = (t % 2 == 1) ? 2'b10 : 2'b01;
            ea = (t % 2 == 1) ? 3'd2 : 3'd1;
            core_rd_data = 32'h1000 + t;
            @(negedge aclk);
            vec_cnt++; if (req_ready !== eg) begin err_cnt++; $display("FAIL fair_grant%0d: got %b exp %b", t, req_ready, eg); end
            next_cycle();
            @(negedge aclk);
            vec_cnt++; if ({core_rd_valid_in, core_rd_addr} !== {1'b1, ea}) begin err_cnt++; $display("FAIL fair_read%0d: got %b/%0d exp 1/%0d", t, core_rd_valid_in, core_rd_addr, ea); end
            vec_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL fair_noready_rd%0d: got %b exp 00", t, req_ready); end
            next_cycle();
            @(negedge aclk);
            vec_cnt++; if (rsp_valid !== eg) begin err_cnt++; $display("FAIL fair_rsp%0d: got %b exp %b", t, rsp_valid, eg); end
            vec_cnt++; if (rsp_data !== 32'h1000 + t) begin err_cnt++; $display("FAIL fair_data%0d: got %h exp %h", t, rsp_data, 32'h1000 + t); end
            vec_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL fair_noready_rsp%0d: got %b exp 00", t, req_ready); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_read_delay();
        set_req(0, 1'b0, 3'd5, 32'h0);
        @(negedge aclk);
        vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL rd3_accept: got %b exp 01", req_ready); end
        next_cycle();
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            core_rd_valid_out = (c == 3);
            core_rd_data = (c == 3) ? 32'h12345678 : 32'hBAD0BAD0;
            @(negedge aclk);
            vec_cnt++; if ({core_rd_valid_in, core_rd_addr} !== 4'b1101) begin err_cnt++; $display("FAIL rd3_c%0d: got %b/%0d exp 1/5", c, core_rd_valid_in, core_rd_addr); end
            next_cycle();
        end
        core_rd_valid_out = 1'b0;
        @(negedge aclk);
        vec_cnt++; if (core_rd_valid_in !== 1'b0) begin err_cnt++; $display("FAIL rd3_len: got %b exp 0", core_rd_valid_in); end
        vec_cnt++; if ({rsp_valid, rsp_err} !== 3'b010) begin err_cnt++; $display("FAIL rd3_rsp: got valid=%b err=%b exp 01/0", rsp_valid, rsp_err); end
        vec_cnt++; if (rsp_data !== 32'h12345678) begin err_cnt++; $display("FAIL rd3_data: got %h exp 12345678", rsp_data); end
        rsp_ready = 2'b01;
        next_cycle();
        rsp_ready = '0;
    endtask

    task automatic test_timeout();
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        set_req(1, 1'b0, 3'd6, 32'h0);
        @(negedge aclk);
        vec_cnt++; if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL to_accept: got %b exp 10", req_ready); end
        next_cycle();
        req_valid = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge aclk);
            if (core_rd_valid_in) begin n++; next_cycle(); end
            else done = 1'b1;
        end
        vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL to_bound: got no end of read, exp end within 40 cycles"); end
        vec_cnt++; if (n !== 16) begin err_cnt++; $display("FAIL to_len: got %0d exp 16", n); end
        vec_cnt++; if ({rsp_valid, rsp_err} !== 3'b101) begin err_cnt++; $display("FAIL to_rsp: got valid=%b err=%b exp 10/1", rsp_valid, rsp_err); end
        vec_cnt++; if (rsp_data !== 32'h0) begin err_cnt++; $display("FAIL to_data: got %h exp 0", rsp_data); end
        core_rd_valid_out = 1'b1;
        core_rd_data = 32'hFFFF_FFFF;
        next_cycle();
        @(negedge aclk);
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 1'b1, 32'h0}) begin err_cnt++; $display("FAIL to_late: got %b/%b/%h exp 10/1/0", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 2'b10;
        next_cycle();
        rsp_ready = '0;
        @(negedge aclk);
        vec_cnt++; if ({rsp_valid, core_rd_valid_in, rsp_err} !== 4'b0) begin err_cnt++; $display("FAIL to_done: got %b exp 0000", {rsp_valid, core_rd_valid_in, rsp_err}); end
        core_rd_valid_out = 1'b0;
        next_cycle();
    endtask

    task automatic test_wr_err_backpressure();
        set_req(1, 1'b1, 3'd2, 32'h55AA55AA);
        core_wr_err = 1'b1;
        @(negedge aclk);
        vec_cnt++; if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL we_accept: got %b exp 10", req_ready); end
        next_cycle();
        req_valid = '0;
        @(negedge aclk);
        vec_cnt++; if ({core_wr_en, core_wr_addr, core_wr_data} !== {1'b1, 3'd2, 32'h55AA55AA}) begin err_cnt++; $display("FAIL we_strobe: got %b/%0d/%h exp 1/2/55aa55aa", core_wr_en, core_wr_addr, core_wr_data); end
        next_cycle();
        core_wr_err = 1'b0;
        rsp_ready = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            vec_cnt++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 1'b1, 32'h0}) begin err_cnt++; $display("FAIL we_hold%0d: got %b/%b/%h exp 10/1/0", c, rsp_valid, rsp_err, rsp_data); end
            next_cycle();
        end
        rsp_ready = 2'b10;
        @(negedge aclk);
        vec_cnt++; if ({rsp_valid, rsp_err} !== 3'b101) begin err_cnt++; $display("FAIL we_hs_cycle: got %b/%b exp 10/1", rsp_valid, rsp_err); end
        next_cycle();
        rsp_ready = '0;
        @(negedge aclk);
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_data} !== 35'b0) begin err_cnt++; $display("FAIL we_clear: got %b/%b/%h exp 00/0/0", rsp_valid, rsp_err, rsp_data); end
        next_cycle();
    endtask

    task automatic test_read_race();
        set_req(0, 1'b0, 3'd1, 32'h0);
        @(negedge aclk);
        vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL race_accept: got %b exp 01", req_ready); end
        next_cycle();
        req_valid = '0;
        for (int c = 1; c <= 16; c++) begin
            core_rd_valid_out = (c == 16);
            core_rd_data = 32'hCAFEF00D;
            @(negedge aclk);
            vec_cnt++; if (core_rd_valid_in !== 1'b1) begin err_cnt++; $display("FAIL race_rd%0d: got %b exp 1", c, core_rd_valid_in); end
            next_cycle();
        end
        core_rd_valid_out = 1'b0;
        @(negedge aclk);
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, 32'hCAFEF00D}) begin err_cnt++; $display("FAIL race_rsp: got %b/%b/%h exp 01/0/cafef00d", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 2'b01;
        next_cycle();
        rsp_ready = '0;
    endtask

    task automatic test_reset_mid_read();
        set_req(1, 1'b0, 3'd4, 32'h0);
        @(negedge aclk);
        vec_cnt++; if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL mr_accept: got %b exp 10", req_ready); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        vec_cnt++; if (core_rd_valid_in !== 1'b1) begin err_cnt++; $display("FAIL mr_reading: got %b exp 1", core_rd_valid_in); end
        req_valid = 2'b11;
        #1 arstn = 1'b0;
        #1;
        vec_cnt++; if ({req_ready, rsp_valid, rsp_err, core_wr_en, core_rd_valid_in} !== 7'b0) begin err_cnt++; $display("FAIL mr_ctrl_zero: got %b exp 0", {req_ready, rsp_valid, rsp_err, core_wr_en, core_rd_valid_in}); end
        vec_cnt++; if ({rsp_data, core_wr_data, core_wr_addr, core_rd_addr} !== 70'b0) begin err_cnt++; $display("FAIL mr_data_zero: got %h exp 0", {rsp_data, core_wr_data, core_wr_addr, core_rd_addr}); end
        req_valid = '0;
        repeat (2) @(posedge aclk);
        #1 arstn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            vec_cnt++; if ({rsp_valid, core_rd_valid_in} !== 3'b0) begin err_cnt++; $display("FAIL mr_no_rsp%0d: got %b exp 000", c, {rsp_valid, core_rd_valid_in}); end
            next_cycle();
        end
        set_req(0, 1'b0, 3'd0, 32'h0);
        set_req(1, 1'b0, 3'd7, 32'h0);
        @(negedge aclk);
        vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL mr_tie: got %b exp 01", req_ready); end
        req_valid[0] = 1'b0;
        #1;
        vec_cnt++; if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL mr_drop: got %b exp 10", req_ready); end
        next_cycle();
        req_valid = '0;
        core_rd_valid_out = 1'b1;
        core_rd_data = 32'h0BADC0DE;
        @(negedge aclk);
        vec_cnt++; if ({core_rd_valid_in, core_rd_addr} !== 4'b1111) begin err_cnt++; $display("FAIL mr_rd: got %b/%0d exp 1/7", core_rd_valid_in, core_rd_addr); end
        next_cycle();
        core_rd_valid_out = 1'b0;
        @(negedge aclk);
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 1'b0, 32'h0BADC0DE}) begin err_cnt++; $display("FAIL mr_rsp: got %b/%b/%h exp 10/0/0badc0de", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 2'b10;
        next_cycle();
        rsp_ready = '0;
        @(negedge aclk);
        vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL mr_done: got %b exp 00", rsp_valid); end
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        arstn = 1'b0;
        test_reset();
        test_write();
        test_fairness();
        test_read_delay();
        test_timeout();
        test_wr_err_backpressure();
        test_read_race();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
